// File: rtl/weight_load_ctrl_pkg.sv
// Shared types and default geometry for the weight loading controller.
package weight_load_pkg;

  localparam int DEF_N    = 16;
  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 8;
  localparam int DEF_WGS  = 3;

  // Index port widths are fixed by the array addressing bus.
  localparam int ROW_W = 2;
  localparam int COL_W = 3;
  localparam int WG_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Handshake and staging-write bus of the weight loading controller.
// The abort signal exists only when WEIGHT_LOAD_ABORT_EN is defined.
interface weight_load_if
  import weight_load_pkg::*;
#(
  parameter int N = DEF_N
) ();

  logic             start;
  logic             in_valid;
  logic [N-1:0]     in_data;
  logic             in_ready;
  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [WG_W-1:0]  wr_wg;
  logic [N-1:0]     wr_data;
  logic             update_en;
  logic             busy;
  logic             done;

`ifdef WEIGHT_LOAD_ABORT_EN
  logic             abort;

  modport master (
    output start, in_valid, in_data, abort,
    input  in_ready, wr_en, wr_row, wr_col, wr_wg, wr_data, update_en, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, abort,
    output in_ready, wr_en, wr_row, wr_col, wr_wg, wr_data, update_en, busy, done
  );
`else
  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_row, wr_col, wr_wg, wr_data, update_en, busy, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_row, wr_col, wr_wg, wr_data, update_en, busy, done
  );
`endif

endinterface

// File: rtl/weight_load_ctrl_idx_cnt.sv
// Nested wg/col/row index counter; wg advances fastest, clr wins over inc.
module weight_idx_cnt
  import weight_load_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int WGS  = DEF_WGS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [WG_W-1:0]  wg,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [WG_W-1:0]  WG_MAX  = WG_W'(WGS - 1);

  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;
  logic [WG_W-1:0]  wg_r;

  // Index registers with carry from wg into col into row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_r <= {ROW_W{1'b0}};
      col_r <= {COL_W{1'b0}};
      wg_r  <= {WG_W{1'b0}};
    end else if (clr) begin
      row_r <= {ROW_W{1'b0}};
      col_r <= {COL_W{1'b0}};
      wg_r  <= {WG_W{1'b0}};
    end else if (inc) begin
      if (wg_r == WG_MAX) begin
        wg_r <= {WG_W{1'b0}};
        if (col_r == COL_MAX) begin
          col_r <= {COL_W{1'b0}};
          if (row_r == ROW_MAX) begin
            row_r <= {ROW_W{1'b0}};
          end else begin
            row_r <= row_r + ROW_W'(1);
          end
        end else begin
          col_r <= col_r + COL_W'(1);
        end
      end else begin
        wg_r <= wg_r + WG_W'(1);
      end
    end else begin
      row_r <= row_r;
      col_r <= col_r;
      wg_r  <= wg_r;
    end
  end

  assign row  = row_r;
  assign col  = col_r;
  assign wg   = wg_r;
  assign last = (row_r == ROW_MAX) && (col_r == COL_MAX) && (wg_r == WG_MAX);

endmodule

// File: rtl/weight_load_ctrl.sv
// Streams a full weight set into PE staging registers, then pulses update_en and done.
// Optional abort input is enabled by defining WEIGHT_LOAD_ABORT_EN.
module weight_load_ctrl
  import weight_load_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int WGS  = DEF_WGS
) (
  input  logic          clk,
  input  logic          reset,
  weight_load_if.slave  bus
);

  state_t           state_r;
  logic             in_ready_r;
  logic             update_en_r;
  logic             busy_r;
  logic             done_r;

  logic             xfer_s;
  logic             last_s;
  logic             abort_s;
  logic             cnt_clr_s;
  logic [ROW_W-1:0] row_s;
  logic [COL_W-1:0] col_s;
  logic [WG_W-1:0]  wg_s;
  logic [N-1:0]     data_s;

`ifdef WEIGHT_LOAD_ABORT_EN
  assign abort_s = bus.abort & (state_r == ST_LOAD);
`else
  assign abort_s = 1'b0;
`endif

  // in_ready_r is high exactly in LOAD, so it doubles as the state qualifier.
  assign xfer_s    = bus.in_valid & in_ready_r;
  assign cnt_clr_s = abort_s | (xfer_s & last_s);

  weight_idx_cnt #(
    .ROWS (ROWS),
    .COLS (COLS),
    .WGS  (WGS)
  ) u_idx_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (xfer_s),
    .clr   (cnt_clr_s),
    .row   (row_s),
    .col   (col_s),
    .wg    (wg_s),
    .last  (last_s)
  );

  // Control FSM; status outputs are registered alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      update_en_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      update_en_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r    <= ST_LOAD;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (abort_s) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
          end else if (xfer_s && last_s) begin
            state_r     <= ST_COMMIT;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b1;
            update_en_r <= 1'b1;
          end else begin
            state_r    <= ST_LOAD;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        ST_COMMIT: begin
          state_r    <= ST_DONE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b1;
          done_r     <= 1'b1;
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign data_s        = bus.in_data;
  assign bus.in_ready  = in_ready_r;
  assign bus.wr_en     = xfer_s;
  assign bus.wr_data   = data_s;
  assign bus.wr_row    = row_s;
  assign bus.wr_col    = col_s;
  assign bus.wr_wg     = wg_s;
  assign bus.update_en = update_en_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed self-checking bench for weight_load_ctrl (abort case needs WEIGHT_LOAD_ABORT_EN).
module tb_weight_load_ctrl;

  localparam int R   = 4;
  localparam int C   = 8;
  localparam int W   = 3;
  localparam int TOT = R * C * W;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  weight_load_if #(.N(16)) bus ();

  weight_load_ctrl #(.N(16), .ROWS(R), .COLS(C), .WGS(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        valid;
    logic [15:0] data;
    logic        e_ready;
    logic        e_wr;
    logic [1:0]  e_row;
    logic [2:0]  e_col;
    logic [1:0]  e_wg;
    logic        e_upd;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // mode 0: continuous, 1: in_valid toggling, 2: start held during the load
  task automatic run_load(input int mode, input string tag);
    int   k, p, wr_cnt, upd_cnt, done_cnt, upd_cyc, done_cyc, exp_upd;
    logic v;
    k = 0; p = 0; wr_cnt = 0; upd_cnt = 0; done_cnt = 0; upd_cyc = -1; done_cyc = -1;
    exp_upd = (mode == 1) ? 2 * TOT : TOT + 1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.in_valid = 1'b0;
    for (int cyc = 1; cyc < 400 && p < 4; cyc++) begin
      @(posedge clk); #1;
      v = (k < TOT && mode == 1) ? (cyc % 2 == 1) : 1'b1;
      bus.start    = (mode == 2) && (k < TOT || p < 2);
      bus.in_valid = v;
      bus.in_data  = (k < TOT) ? 16'(k) : 16'hBEEF;
      #2;
      if (bus.wr_en)     wr_cnt++;
      if (bus.update_en) begin upd_cnt++;  upd_cyc  = cyc; end
      if (bus.done)      begin done_cnt++; done_cyc = cyc; end
      if (k < TOT) begin
        chk({tag, "_ready"}, bus.in_ready, 1'b1);
        chk({tag, "_busy"},  bus.busy, 1'b1);
        chk({tag, "_wr_en"}, bus.wr_en, v);
        chk({tag, "_row"},   bus.wr_row, k / (C * W));
        chk({tag, "_col"},   bus.wr_col, (k / W) % C);
        chk({tag, "_wg"},    bus.wr_wg, k % W);
        if (v) chk({tag, "_data"}, bus.wr_data, k);
        if (mode == 0 && k == 25) begin
          chk("word25_row", bus.wr_row, 1);
          chk("word25_col", bus.wr_col, 0);
          chk("word25_wg",  bus.wr_wg, 1);
        end
        if (v) k++;
      end else begin
        p++;
        chk({tag, "_post_ready"}, bus.in_ready, 1'b0);
        chk({tag, "_post_wr_en"}, bus.wr_en, 1'b0);
        chk({tag, "_post_upd"},   bus.update_en, (p == 1));
        chk({tag, "_post_done"},  bus.done, (p == 2));
        chk({tag, "_post_busy"},  bus.busy, (p < 3));
      end
    end
    chk({tag, "_finished"},  p, 4);
    chk({tag, "_wr_count"},  wr_cnt, TOT);
    chk({tag, "_upd_count"}, upd_cnt, 1);
    chk({tag, "_done_cnt"},  done_cnt, 1);
    chk({tag, "_upd_cycle"}, upd_cyc, exp_upd);
    chk({tag, "_done_cyc"},  done_cyc, exp_upd + 1);
    bus.start = 1'b0; bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    clk = 1'b0; reset = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 16'h0000;
`ifdef WEIGHT_LOAD_ABORT_EN
    bus.abort = 1'b0;
`endif

    //          start valid data      rdy  wr   row   col   wg    upd  busy done
    vecs[0] = '{1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'h5555, 1'b1, 1'b0, 2'd0, 3'd0, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 2'd0, 3'd0, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 2'd0, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 3'd1, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 3'd1, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 16'h0003, 1'b1, 1'b1, 2'd0, 3'd1, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 16'h0004, 1'b1, 1'b1, 2'd0, 3'd1, 2'd1, 1'b0, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.start = vecs[i].start; bus.in_valid = vecs[i].valid; bus.in_data = vecs[i].data;
      #2;
      chk($sformatf("vec%0d_ready", i), bus.in_ready, vecs[i].e_ready);
      chk($sformatf("vec%0d_wr_en", i), bus.wr_en, vecs[i].e_wr);
      chk($sformatf("vec%0d_row", i),   bus.wr_row, vecs[i].e_row);
      chk($sformatf("vec%0d_col", i),   bus.wr_col, vecs[i].e_col);
      chk($sformatf("vec%0d_wg", i),    bus.wr_wg, vecs[i].e_wg);
      chk($sformatf("vec%0d_upd", i),   bus.update_en, vecs[i].e_upd);
      chk($sformatf("vec%0d_busy", i),  bus.busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_done", i),  bus.done, vecs[i].e_done);
      if (vecs[i].e_wr) chk($sformatf("vec%0d_data", i), bus.wr_data, vecs[i].data);
    end

    do_reset();
    run_load(0, "cont");
    do_reset();
    run_load(1, "toggle");
    do_reset();
    run_load(2, "hold");

    // Reset after 40 words, then a fresh load must restart at index zero
    do_reset();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'(i);
    end
    @(posedge clk); #1;
    chk("pre_rst_col", bus.wr_col, 3'd5);
    reset = 1'b1;
    #2;
    chk("rst_ready", bus.in_ready, 1'b0);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_row",   bus.wr_row, 2'd0);
    chk("rst_col",   bus.wr_col, 3'd0);
    chk("rst_wg",    bus.wr_wg, 2'd0);
    chk("rst_upd",   bus.update_en, 1'b0);
    chk("rst_busy",  bus.busy, 1'b0);
    chk("rst_done",  bus.done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #3;
      chk("after_rst_upd",  bus.update_en, 1'b0);
      chk("after_rst_busy", bus.busy, 1'b0);
      chk("after_rst_wr",   bus.wr_en, 1'b0);
    end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h1234;
    #2;
    chk("restart_wr_en", bus.wr_en, 1'b1);
    chk("restart_row",   bus.wr_row, 2'd0);
    chk("restart_col",   bus.wr_col, 3'd0);
    chk("restart_wg",    bus.wr_wg, 2'd0);
    chk("restart_data",  bus.wr_data, 16'h1234);

`ifdef WEIGHT_LOAD_ABORT_EN
    // Abort coinciding with the final word must suppress commit entirely
    do_reset();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.in_valid = 1'b0;
    for (int i = 0; i < TOT - 1; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'(i);
    end
    @(posedge clk); #1;
    bus.abort = 1'b1; bus.in_data = 16'(TOT - 1);
    #2;
    chk("abort_last_row", bus.wr_row, 2'd3);
    chk("abort_last_col", bus.wr_col, 3'd7);
    chk("abort_last_wg",  bus.wr_wg, 2'd2);
    @(posedge clk); #1;
    bus.abort = 1'b0;
    #2;
    chk("abort_busy",  bus.busy, 1'b0);
    chk("abort_ready", bus.in_ready, 1'b0);
    chk("abort_upd",   bus.update_en, 1'b0);
    chk("abort_done",  bus.done, 1'b0);
    chk("abort_row",   bus.wr_row, 2'd0);
    @(posedge clk); #3;
    chk("abort_upd2",  bus.update_en, 1'b0);
    chk("abort_done2", bus.done, 1'b0);
    bus.in_valid = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
